game_lives_multi: RTL
=====================

Name: game_lives_multi

Overview:
- Parametrised lives/health tracker for 1..4 Bombermen.
- Per player: a lives counter, a post-hit invulnerability window, an extra-life pickup input and a dead flag.
- Global: a gameover flag and a registered HUD pixel stream that draws one pip bar per player.
- Sits between the pixel-level collision logic (hitbox / enemy / explosion on-signals) and the RGB mux, alongside the arena and sprite generators.

Parameters:
- N_PLAYERS, 2, number of players tracked (1..4).
- MAX_LIVES, 5, lives at reset/restart and saturation cap for pickups (1..7).
- INVULN_CYCLES, 150000000, invulnerability window length in clk cycles after a hit (≥2).
- HUD_X0, 550, left x edge of every player's bar (exclusive).
- HUD_Y0, 20, top y edge of player 0's bar (exclusive).
- ROW_PITCH, 10, y offset between consecutive players' bars.
- PIP_W, 4, pip width in pixels including a 1-px gap; power of two, ≥2.
- PIP_H, 8, bar height; row i is lit for HUD_Y0+i*ROW_PITCH < y < HUD_Y0+i*ROW_PITCH+PIP_H.
- PLAYER_RGB, {4{12'hA00}}, packed 12-bit colour per player; player i uses bits [12i+11:12i].
- BLINK_BIT, 23, invulnerability-counter bit that drives blinking (optional feature only).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- x  in  10  current pixel x
- y  in  10  current pixel y
- hb_on  in  N_PLAYERS  player i hitbox covers current pixel
- enemy_on  in  1  enemy sprite covers current pixel
- exp_on  in  1  explosion covers current pixel
- extra_life  in  N_PLAYERS  1-cycle pickup pulse per player
- restart  in  1  synchronous 1-cycle new-game pulse
- lives  out  3*N_PLAYERS  packed lives count, player i at [3i+2:3i]
- invuln  out  N_PLAYERS  player i in invulnerability window
- hit_pulse  out  N_PLAYERS  1-cycle pulse on an accepted hit
- dead  out  N_PLAYERS  player i has 0 lives
- gameover  out  1  all players dead
- hud_on  out  1  current pixel lies on a lit pip (registered)
- hud_rgb  out  12  pip colour, 12'h000 when hud_on=0 (registered)

Behaviour:
- Reset (reset_n low, async):
  - lives=MAX_LIVES; state ALIVE; invulnerability counter=0.
  - invuln, hit_pulse, dead, gameover, hud_on = 0; hud_rgb=0.
- hit_i = hb_on[i] & (enemy_on | exp_on), sampled each cycle.
- Per-player FSM {ALIVE, INVULN, DEAD}:
  - ALIVE & hit_i & lives>1: lives-1 → INVULN; counter loads INVULN_CYCLES; hit_pulse=1 next cycle.
  - ALIVE & hit_i & lives==1: lives=0 → DEAD; hit_pulse=1.
  - INVULN: counter decrements every cycle; all hits ignored; at counter==1 → ALIVE next cycle with counter=0. The window is exactly INVULN_CYCLES cycles with invuln=1.
  - DEAD: hits and extra_life ignored; exit only via restart or reset.
- extra_life in ALIVE or INVULN: lives+1, saturating at MAX_LIVES; does not change state or counter.
- Same cycle hit and extra_life in ALIVE: net lives unchanged, enter INVULN, hit_pulse=1. At lives==1 the player survives with 1 life and goes to INVULN, not DEAD.
- restart: every player returns to MAX_LIVES, ALIVE, counter 0; takes priority over hits and pickups in the same cycle.
- Outputs:
  - invuln = (state==INVULN).
  - dead = (state==DEAD).
  - gameover = AND of all dead bits, combinational from registers.
- Collisions are evaluated once per pixel-cycle. Multiple overlapping pixels in one frame produce one hit, because INVULN masks the rest.
- HUD, for row i:
  - d = x - HUD_X0 - 1.
  - Pixel is lit when x>HUD_X0, d < lives_i*PIP_W, d mod PIP_W != PIP_W-1, and y is inside row i.
  - Rows must not overlap (ROW_PITCH ≥ PIP_H); the lowest-index lit row wins.
  - hud_on/hud_rgb are registered: 1-cycle latency from x/y.
  - A row with lives=0 draws nothing.
- Widths:
  - Counter width is clog2(INVULN_CYCLES+1).
  - The lives*PIP_W product is computed at width ≥10 bits, so no wrap.

Optional Feature:
- Macro: GAME_LIVES_BLINK_EN.
- Defined: while player i is INVULN, row i is blanked when counter bit BLINK_BIT is 1, so the bar flashes. ALIVE rows always draw.
- Undefined: rows draw regardless of invulnerability, and BLINK_BIT is unused.

Test Plan:
- Reset, N_PLAYERS=2, MAX_LIVES=5 → lives={5,5}, invuln=0, dead=0, gameover=0, hud_rgb=0.
- INVULN_CYCLES=10; hb_on[0]=1 & exp_on=1 held 30 cycles → lives0=4 (one decrement only), hit_pulse[0] high exactly 1 cycle, invuln[0] high exactly 10 cycles, then a second hit → lives0=3.
- Player 1 at 1 life, hit and extra_life[1] same cycle → lives1=1, invuln[1]=1, dead[1]=0. Then hit after window → lives1=0, dead[1]=1. extra_life[1] afterwards → still 0.
- Both players driven to 0 → gameover=1. restart pulse → lives={5,5}, gameover=0 next cycle. extra_life at 5 → stays 5.
- lives0=3, PIP_W=4, scan y=24: pixel at x=551 lit, x=554 (gap) dark, x=563 dark. hud_on appears 1 cycle after x/y and hud_rgb=12'hA00.
- With GAME_LIVES_BLINK_EN, BLINK_BIT=2, INVULN_CYCLES=20: row 0 alternates lit/dark every 4 cycles during INVULN; steady lit once ALIVE.

Source files
------------

// File: rtl/game_lives_multi.sv
// Lives/invulnerability tracker for 1..4 players with a registered HUD pip-bar overlay.
// Optional: define GAME_LIVES_BLINK_EN to flash a player's bar while invulnerable.
//
// state     | meaning
// ST_ALIVE  | player can be hit; hits cost a life
// ST_INVULN | post-hit window, counter running, hits ignored
// ST_DEAD   | no lives left; only restart/reset leave this state
module game_lives_multi #(
    parameter int          N_PLAYERS     = 2,
    parameter int          MAX_LIVES     = 5,
    parameter int          INVULN_CYCLES = 150000000,
    parameter int          HUD_X0        = 550,
    parameter int          HUD_Y0        = 20,
    parameter int          ROW_PITCH     = 10,
    parameter int          PIP_W         = 4,
    parameter int          PIP_H         = 8,
    parameter logic [47:0] PLAYER_RGB    = {4{12'hA00}},
    parameter int          BLINK_BIT     = 23
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [9:0]               x,
    input  logic [9:0]               y,
    input  logic [N_PLAYERS-1:0]     hb_on,
    input  logic                     enemy_on,
    input  logic                     exp_on,
    input  logic [N_PLAYERS-1:0]     extra_life,
    input  logic                     restart,
    output logic [3*N_PLAYERS-1:0]   lives,
    output logic [N_PLAYERS-1:0]     invuln,
    output logic [N_PLAYERS-1:0]     hit_pulse,
    output logic [N_PLAYERS-1:0]     dead,
    output logic                     gameover,
    output logic                     hud_on,
    output logic [11:0]              hud_rgb
);

    localparam int              CW        = $clog2(INVULN_CYCLES + 1);
    localparam int              PW_B      = $clog2(PIP_W);
    localparam logic [2:0]      LIVES_MAX = 3'(MAX_LIVES);
    localparam logic [CW-1:0]   CNT_LOAD  = CW'(INVULN_CYCLES);
    localparam logic [PW_B-1:0] PIP_LAST  = PW_B'(PIP_W - 1);
    localparam logic [11:0]     X0        = 12'(HUD_X0);

    typedef enum logic [1:0] {ST_ALIVE, ST_INVULN, ST_DEAD} state_t;

    state_t               state_q [N_PLAYERS];
    state_t               state_d [N_PLAYERS];
    logic [2:0]           lives_q [N_PLAYERS];
    logic [2:0]           lives_d [N_PLAYERS];
    logic [CW-1:0]        cnt_q   [N_PLAYERS];
    logic [CW-1:0]        cnt_d   [N_PLAYERS];
    logic [N_PLAYERS-1:0] hit;
    logic [N_PLAYERS-1:0] hit_pulse_d;
    logic [N_PLAYERS-1:0] row_lit;
    logic [11:0]          x_ext, y_ext, d;
    logic                 hud_on_d;
    logic [11:0]          hud_rgb_d;

    function automatic logic [2:0] inc_sat(input logic [2:0] v);
        return (v < LIVES_MAX) ? v + 3'd1 : v;
    endfunction

    assign hit = hb_on & {N_PLAYERS{enemy_on | exp_on}};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_PLAYERS; i++) begin
                state_q[i] <= ST_ALIVE;
                lives_q[i] <= LIVES_MAX;
                cnt_q[i]   <= '0;
            end
            hit_pulse <= '0;
            hud_on    <= 1'b0;
            hud_rgb   <= 12'h000;
        end else begin
            for (int i = 0; i < N_PLAYERS; i++) begin
                state_q[i] <= state_d[i];
                lives_q[i] <= lives_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            hit_pulse <= hit_pulse_d;
            hud_on    <= hud_on_d;
            hud_rgb   <= hud_rgb_d;
        end
    end

    always_comb begin
        hit_pulse_d = '0;
        for (int i = 0; i < N_PLAYERS; i++) begin
            state_d[i] = state_q[i];
            lives_d[i] = lives_q[i];
            cnt_d[i]   = cnt_q[i];
            if (restart) begin
                state_d[i] = ST_ALIVE;
                lives_d[i] = LIVES_MAX;
                cnt_d[i]   = '0;
            end else begin
                unique case (state_q[i])
                    ST_ALIVE: begin
                        if (hit[i]) begin
                            hit_pulse_d[i] = 1'b1;
                            // a simultaneous pickup cancels the life loss, even at 1 life
                            if (extra_life[i] || lives_q[i] > 3'd1) begin
                                if (!extra_life[i]) lives_d[i] = lives_q[i] - 3'd1;
                                state_d[i] = ST_INVULN;
                                cnt_d[i]   = CNT_LOAD;
                            end else begin
                                lives_d[i] = 3'd0;
                                state_d[i] = ST_DEAD;
                            end
                        end else if (extra_life[i]) begin
                            lives_d[i] = inc_sat(lives_q[i]);
                        end
                    end
                    ST_INVULN: begin
                        if (extra_life[i]) lives_d[i] = inc_sat(lives_q[i]);
                        if (cnt_q[i] == CW'(1)) begin
                            state_d[i] = ST_ALIVE;
                            cnt_d[i]   = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] - CW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        x_ext     = {2'b00, x};
        y_ext     = {2'b00, y};
        d         = x_ext - X0 - 12'd1;
        hud_on_d  = 1'b0;
        hud_rgb_d = 12'h000;
        for (int i = 0; i < N_PLAYERS; i++) begin
            row_lit[i] = (x_ext > X0)
                      && (d < 12'(lives_q[i]) * 12'(PIP_W))
                      && (d[PW_B-1:0] != PIP_LAST)
                      && (y_ext > 12'(HUD_Y0 + i * ROW_PITCH))
                      && (y_ext < 12'(HUD_Y0 + i * ROW_PITCH + PIP_H));
`ifdef GAME_LIVES_BLINK_EN
            if (state_q[i] == ST_INVULN && cnt_q[i][BLINK_BIT]) row_lit[i] = 1'b0;
`endif
        end
        // walk high-to-low so the lowest-index lit row ends up selected
        for (int i = N_PLAYERS - 1; i >= 0; i--) begin
            if (row_lit[i]) begin
                hud_on_d  = 1'b1;
                hud_rgb_d = PLAYER_RGB[12*i +: 12];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_PLAYERS; i++) begin
            lives[3*i +: 3] = lives_q[i];
            invuln[i]       = (state_q[i] == ST_INVULN);
            dead[i]         = (state_q[i] == ST_DEAD);
        end
        gameover = &dead;
    end

endmodule
